// File: rtl/if_id_skid_stage.sv
// IF/ID two-entry skid buffer: registered ready, strict FIFO order,
// flush to NOP, and a saturating backpressure-cycle counter.
//
// Ports:
//   Clk, Reset        clock and synchronous active-high reset
//   Flush             drops every held pair at the next edge
//   Instruction_IF,   fetched pair offered by IF,
//   PC_Plus_4_IF,     qualified by In_Valid;
//   In_Valid,         In_Ready says a pair can be taken
//   In_Ready          this cycle (registered state only)
//   Instruction_ID,   head pair presented to ID,
//   PC_Plus_4_ID,     qualified by Out_Valid;
//   Out_Valid,        Out_Ready takes the head this cycle
//   Out_Ready
//   Occupancy         number of held pairs (0..2)
//   Stall_Count       saturating count of valid-but-not-ready edges
module if_id_skid_stage #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Flush,
  input  logic [INSTR_WIDTH-1:0] Instruction_IF,
  input  logic [PC_WIDTH-1:0]    PC_Plus_4_IF,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  output logic [INSTR_WIDTH-1:0] Instruction_ID,
  output logic [PC_WIDTH-1:0]    PC_Plus_4_ID,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [1:0]             Occupancy,
  output logic [CNT_WIDTH-1:0]   Stall_Count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [INSTR_WIDTH-1:0] main_instr_q;
  logic [INSTR_WIDTH-1:0] main_instr_d;
  logic [PC_WIDTH-1:0]    main_pc_q;
  logic [PC_WIDTH-1:0]    main_pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q;
  logic [INSTR_WIDTH-1:0] skid_instr_d;
  logic [PC_WIDTH-1:0]    skid_pc_q;
  logic [PC_WIDTH-1:0]    skid_pc_d;
  logic [CNT_WIDTH-1:0]   stall_q;

  logic accept;
  logic consume;
  logic stall;
  logic stall_sat;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Handshake flags decode from the state register only,
  // so In_Ready never sees Out_Ready combinationally.
  always_comb begin
    In_Ready  = 1'b1;
    Out_Valid = 1'b0;
    Occupancy = 2'd0;
    unique case (state_q)
      EMPTY: begin
        In_Ready  = 1'b1;
        Out_Valid = 1'b0;
        Occupancy = 2'd0;
      end
      ONE: begin
        In_Ready  = 1'b1;
        Out_Valid = 1'b1;
        Occupancy = 2'd1;
      end
      TWO: begin
        In_Ready  = 1'b0;
        Out_Valid = 1'b1;
        Occupancy = 2'd2;
      end
      default: begin
        In_Ready  = 1'b1;
        Out_Valid = 1'b0;
        Occupancy = 2'd0;
      end
    endcase
  end

  assign accept  = In_Valid & In_Ready;
  assign consume = Out_Valid & Out_Ready;

  assign Instruction_ID = main_instr_q;
  assign PC_Plus_4_ID   = main_pc_q;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (Flush) begin
      // Handshakes in a flush cycle are dropped.
      state_d      = EMPTY;
      main_instr_d = NOP_INSTR;
      main_pc_d    = '0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            main_instr_d = Instruction_IF;
            main_pc_d    = PC_Plus_4_IF;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept & consume: begin
              main_instr_d = Instruction_IF;
              main_pc_d    = PC_Plus_4_IF;
            end
            accept & ~consume: begin
              state_d      = TWO;
              skid_instr_d = Instruction_IF;
              skid_pc_d    = PC_Plus_4_IF;
            end
            ~accept & consume: begin
              state_d      = EMPTY;
              main_instr_d = NOP_INSTR;
              main_pc_d    = '0;
            end
            default: begin
              state_d = ONE;
            end
          endcase
        end
        TWO: begin
          if (consume) begin
            state_d      = ONE;
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_instr_d = NOP_INSTR;
          main_pc_d    = '0;
        end
      endcase
    end
  end

  // The stall counter ignores Flush; only Reset clears it.
  assign stall     = Out_Valid & ~Out_Ready;
  assign stall_sat = &stall_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= EMPTY;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      if (stall && !stall_sat) begin
        stall_q <= stall_q + CNT_ONE;
      end
    end
  end

  assign Stall_Count = stall_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: queue-based reference model,
// directed scenarios with literal checks, then random traffic.
module tb_if_id_skid_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Flush = 1'b0;
  logic [31:0] Instruction_IF = '0;
  logic [31:0] PC_Plus_4_IF = '0;
  logic        In_Valid = 1'b0;
  logic        Out_Ready = 1'b0;

  logic        In_Ready;
  logic [31:0] Instruction_ID;
  logic [31:0] PC_Plus_4_ID;
  logic        Out_Valid;
  logic [1:0]  Occupancy;
  logic [15:0] Stall_Count;

  logic        s_in_ready;
  logic [31:0] s_instr;
  logic [31:0] s_pc;
  logic        s_out_valid;
  logic [1:0]  s_occ;
  logic [3:0]  s_stall;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [63:0] mq[$];
  int          mcnt = 0;

  always #5 Clk = ~Clk;

  if_id_skid_stage u_dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .Instruction_IF(Instruction_IF),
    .PC_Plus_4_IF(PC_Plus_4_IF),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Instruction_ID(Instruction_ID),
    .PC_Plus_4_ID(PC_Plus_4_ID),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Occupancy(Occupancy), .Stall_Count(Stall_Count)
  );

  if_id_skid_stage #(.CNT_WIDTH(4)) u_sat (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .Instruction_IF(Instruction_IF),
    .PC_Plus_4_IF(PC_Plus_4_IF),
    .In_Valid(In_Valid), .In_Ready(s_in_ready),
    .Instruction_ID(s_instr),
    .PC_Plus_4_ID(s_pc),
    .Out_Valid(s_out_valid), .Out_Ready(Out_Ready),
    .Occupancy(s_occ), .Stall_Count(s_stall)
  );

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of {instr, pc} of depth two.
  always @(posedge Clk) begin
    bit acc;
    bit con;
    if (Reset) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (mq.size() != 0 && !Out_Ready) mcnt++;
      if (Flush) begin
        mq.delete();
      end else begin
        acc = In_Valid && mq.size() < 2;
        con = mq.size() != 0 && Out_Ready;
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back({Instruction_IF, PC_Plus_4_IF});
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge Clk) begin
    logic [63:0] hd;
    int n;
    if (chk_en) begin
      n = mq.size();
      hd = (n != 0) ? mq[0] : 64'd0;
      chk("occ", {62'd0, Occupancy}, 64'(n));
      chk("out_valid", {63'd0, Out_Valid}, {63'd0, n != 0});
      chk("in_ready", {63'd0, In_Ready}, {63'd0, n < 2});
      chk("instr", {32'd0, Instruction_ID}, {32'd0, hd[63:32]});
      chk("pc", {32'd0, PC_Plus_4_ID}, {32'd0, hd[31:0]});
      chk("stall16", {48'd0, Stall_Count},
          64'((mcnt > 65535) ? 65535 : mcnt));
      chk("stall4", {60'd0, s_stall},
          64'((mcnt > 15) ? 15 : mcnt));
      chk("sat_occ", {62'd0, s_occ}, 64'(n));
    end
  end

  task automatic go(bit r, bit f, bit v, logic [31:0] i,
                    logic [31:0] p, bit o);
    Reset = r;
    Flush = f;
    In_Valid = v;
    Instruction_IF = i;
    PC_Plus_4_IF = p;
    Out_Ready = o;
    @(negedge Clk);
  endtask

  initial begin
    go(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    go(1, 0, 0, 0, 0, 0);
    chk("rst_occ", {62'd0, Occupancy}, 64'd0);
    chk("rst_rdy", {63'd0, In_Ready}, 64'd1);
    chk("rst_vld", {63'd0, Out_Valid}, 64'd0);
    chk("rst_pc", {32'd0, PC_Plus_4_ID}, 64'd0);

    // Streaming at one pair per cycle.
    go(0, 0, 1, 32'h11, 32'd4, 1);
    chk("s1", {32'd0, Instruction_ID}, 64'h11);
    go(0, 0, 1, 32'h22, 32'd8, 1);
    chk("s2", {32'd0, Instruction_ID}, 64'h22);
    chk("s2pc", {32'd0, PC_Plus_4_ID}, 64'd8);
    go(0, 0, 1, 32'h33, 32'd12, 1);
    chk("s3", {32'd0, Instruction_ID}, 64'h33);
    chk("s3occ", {62'd0, Occupancy}, 64'd1);
    go(0, 0, 0, 0, 0, 1);
    chk("s_stall", {48'd0, Stall_Count}, 64'd0);

    // Backpressure.
    go(0, 0, 1, 32'hA1, 32'd16, 0);
    go(0, 0, 1, 32'hA2, 32'd20, 0);
    chk("bp_occ", {62'd0, Occupancy}, 64'd2);
    chk("bp_rdy", {63'd0, In_Ready}, 64'd0);
    go(0, 0, 1, 32'hA3, 32'd24, 0);
    chk("bp_head", {32'd0, Instruction_ID}, 64'hA1);
    go(0, 0, 0, 0, 0, 1);
    chk("bp_a2", {32'd0, Instruction_ID}, 64'hA2);
    go(0, 0, 0, 0, 0, 1);
    chk("bp_occ0", {62'd0, Occupancy}, 64'd0);
    chk("bp_stall", {48'd0, Stall_Count}, 64'd2);

    // Flush in TWO with a valid input offered.
    go(0, 0, 1, 32'hB1, 32'd28, 0);
    go(0, 0, 1, 32'hB2, 32'd32, 0);
    go(0, 1, 1, 32'hB3, 32'd36, 1);
    chk("fl_occ", {62'd0, Occupancy}, 64'd0);
    chk("fl_instr", {32'd0, Instruction_ID}, 64'd0);
    chk("fl_pc", {32'd0, PC_Plus_4_ID}, 64'd0);
    go(0, 0, 0, 0, 0, 1);
    chk("fl_vld", {63'd0, Out_Valid}, 64'd0);
    chk("fl_stall", {48'd0, Stall_Count}, 64'd3);

    // Reset plus Flush while in TWO with five stalls.
    go(0, 0, 1, 32'hC1, 32'd40, 0);
    go(0, 0, 1, 32'hC2, 32'd44, 0);
    go(0, 0, 0, 0, 0, 0);
    chk("pre_rst", {48'd0, Stall_Count}, 64'd5);
    go(1, 1, 1, 32'hC3, 32'd48, 1);
    chk("mr_stall", {48'd0, Stall_Count}, 64'd0);
    chk("mr_occ", {62'd0, Occupancy}, 64'd0);
    chk("mr_rdy", {63'd0, In_Ready}, 64'd1);

    // Saturation of the 4-bit counter.
    go(0, 0, 1, 32'hD1, 32'd52, 0);
    for (int k = 0; k < 20; k++) go(0, 0, 0, 0, 0, 0);
    chk("sat4", {60'd0, s_stall}, 64'd15);
    chk("sat16", {48'd0, Stall_Count}, 64'd20);

    // Random traffic.
    go(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      go($urandom_range(0, 99) == 0,
         $urandom_range(0, 15) == 0,
         $urandom_range(0, 1) == 1,
         $urandom, $urandom,
         $urandom_range(0, 9) < 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
